// File: rtl/mot_sched_pkg.sv
// Shared types and constants for the Rojobot motion command scheduler.
package mot_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // MotCtl byte layout
  localparam int LM_SPD_HI = 7;
  localparam int LM_SPD_LO = 5;
  localparam int LM_DIR    = 4;
  localparam int RM_SPD_HI = 3;
  localparam int RM_SPD_LO = 1;
  localparam int RM_DIR    = 0;

  localparam logic [7:0] MOT_STOP = 8'h00;

  localparam int PROX_L_BIT = 4;
  localparam int PROX_R_BIT = 3;

endpackage

// File: rtl/sched_cmd_fifo.sv
// Power-of-2 synchronous FIFO with flush; a push while full is rejected even
// when a pop happens on the same edge.
module sched_cmd_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mot_cmd_sched.sv
// Rojobot motion command scheduler: queues {MotCtl, duration} commands and
// paces them from BOTSIM update toggles. Optional feature macro: PROX_STOP_EN.
module mot_cmd_sched
  import mot_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DUR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_wr,
  input  logic [7:0]             cmd_mot,
  input  logic [DUR_W-1:0]       cmd_dur,
  output logic                   cmd_full,
  output logic [$clog2(DEPTH):0] cmd_count,
  input  logic                   abort,
  input  logic                   upd_sysregs,
  input  logic [7:0]             Sensors,
  output logic [7:0]             MotCtl,
  output logic                   busy,
  output logic                   cmd_done,
  output logic                   overflow
`ifdef PROX_STOP_EN
  ,
  output logic                   prox_stop
`endif
);

  state_e           state_q, state_d;
  logic [7:0]       mot_q, mot_d;
  logic [DUR_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             upd_prev_q;
  logic             tick, kill, prox_hit, pop, empty;
  logic [7+DUR_W:0] head;
  logic [7:0]       head_mot;
  logic [DUR_W-1:0] head_dur;

  assign tick     = upd_sysregs ^ upd_prev_q;
  assign head_mot = head[7+DUR_W:DUR_W];
  // Zero duration runs for a single tick
  assign head_dur = (head[DUR_W-1:0] == '0) ? DUR_W'(1) : head[DUR_W-1:0];

`ifdef PROX_STOP_EN
  logic prox_q;
  assign prox_hit  = (state_q == RUN) && (Sensors[PROX_L_BIT] | Sensors[PROX_R_BIT])
                     && mot_q[LM_DIR] && mot_q[RM_DIR];
  assign prox_stop = prox_q;
  always_ff @(posedge clk) begin
    if (!reset || abort) prox_q <= 1'b0;
    else if (prox_hit)   prox_q <= 1'b1;
  end
`else
  logic unused_sensors;
  assign unused_sensors = ^Sensors;
  assign prox_hit       = 1'b0;
`endif

  assign kill = abort | prox_hit;

  sched_cmd_fifo #(.DEPTH(DEPTH), .W(8 + DUR_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (kill),
    .push_i  (cmd_wr),
    .pop_i   (pop),
    .wdata_i ({cmd_mot, cmd_dur}),
    .rdata_o (head),
    .full_o  (cmd_full),
    .empty_o (empty),
    .count_o (cmd_count)
  );

  always_comb begin
    state_d  = state_q;
    mot_d    = mot_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    ovf_d    = ovf_q | (cmd_wr & cmd_full);
    if (kill) begin
      state_d = IDLE;
      mot_d   = MOT_STOP;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          pop      = 1'b1;
          mot_d    = head_mot;
          remain_d = head_dur;
          state_d  = RUN;
        end
        RUN: if (tick) begin
          if (remain_q > DUR_W'(1)) begin
            remain_d = remain_q - DUR_W'(1);
          end else begin
            done_d = 1'b1;
            // Back-to-back load: no stop cycle between commands
            if (!empty) begin
              pop      = 1'b1;
              mot_d    = head_mot;
              remain_d = head_dur;
            end else begin
              mot_d   = MOT_STOP;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      mot_q    <= MOT_STOP;
      remain_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mot_q    <= mot_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Tracking upd_sysregs through reset leaves no stale toggle on release
  always_ff @(posedge clk) upd_prev_q <= upd_sysregs;

  assign MotCtl   = mot_q;
  assign busy     = (state_q == RUN);
  assign cmd_done = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mot_cmd_sched.sv
// Bench for mot_cmd_sched: directed vector table, hand sequences, and random
// traffic checked against a queue-based command model.
module tb_mot_cmd_sched;

  localparam int DEPTH = 8;
  localparam int DUR_W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [7:0] cmd_mot = 8'h00;
  logic [7:0] cmd_dur = 8'h00;
  logic       cmd_full;
  logic [3:0] cmd_count;
  logic       abort = 1'b0;
  logic       upd_sysregs = 1'b0;
  logic [7:0] Sensors = 8'h00;
  logic [7:0] MotCtl;
  logic       busy, cmd_done, overflow;

  mot_cmd_sched #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .cmd_wr(cmd_wr), .cmd_mot(cmd_mot), .cmd_dur(cmd_dur),
    .cmd_full(cmd_full), .cmd_count(cmd_count), .abort(abort), .upd_sysregs(upd_sysregs),
    .Sensors(Sensors), .MotCtl(MotCtl), .busy(busy), .cmd_done(cmd_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: pending commands, active command and its ticks left
  typedef struct { logic [7:0] mot; logic [7:0] dur; } cmd_t;
  cmd_t       mq[$];
  bit         m_run, m_done, m_ovf, m_prev;
  logic [7:0] m_mot;
  int         m_rem;

  typedef struct {
    bit wr; logic [7:0] mot; logic [7:0] dur; bit ab; bit tog;
    logic [7:0] e_mot; bit e_busy; bit e_done; int e_cnt; bit e_ovf;
  } vec_t;
  vec_t tq[$];

  task automatic addv(input bit wr, input logic [7:0] mot, input logic [7:0] dur,
                      input bit ab, input bit tog, input logic [7:0] e_mot,
                      input bit e_busy, input bit e_done, input int e_cnt, input bit e_ovf);
    vec_t v;
    v.wr = wr; v.mot = mot; v.dur = dur; v.ab = ab; v.tog = tog;
    v.e_mot = e_mot; v.e_busy = e_busy; v.e_done = e_done; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    tq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_load();
    cmd_t c;
    c = mq.pop_front();
    m_mot = c.mot;
    m_rem = (c.dur == 0) ? 1 : int'(c.dur);
    m_run = 1'b1;
  endtask

  task automatic step(input bit rst, input bit wr, input logic [7:0] mot,
                      input logic [7:0] dur, input bit ab, input bit tog);
    bit tick, full;
    cmd_t c;
    reset = ~rst; cmd_wr = wr; cmd_mot = mot; cmd_dur = dur; abort = ab;
    upd_sysregs = upd_sysregs ^ tog;
    Sensors = 8'($urandom);
    if (rst) begin
      mq.delete(); m_run = 0; m_mot = 0; m_rem = 0; m_done = 0; m_ovf = 0;
      m_prev = upd_sysregs;
    end else begin
      tick = upd_sysregs ^ m_prev;
      m_prev = upd_sysregs;
      full = (mq.size() == DEPTH);
      m_done = 0;
      if (ab) begin
        mq.delete(); m_run = 0; m_mot = 0; m_ovf = 0;
      end else begin
        if (!m_run) begin
          if (mq.size() > 0) m_load();
        end else if (tick) begin
          if (m_rem > 1) m_rem--;
          else begin
            m_done = 1;
            if (mq.size() > 0) m_load();
            else begin m_run = 0; m_mot = 0; end
          end
        end
        if (wr) begin
          if (full) m_ovf = 1;
          else begin c.mot = mot; c.dur = dur; mq.push_back(c); end
        end
      end
    end
    @(posedge clk); #1;
    nvec++;
    if (MotCtl !== m_mot || busy !== m_run || cmd_done !== m_done ||
        cmd_count !== 4'(mq.size()) || cmd_full !== (mq.size() == DEPTH) || overflow !== m_ovf) begin
      nmis++;
      $display("FAIL model t=%0t: got mot=%h busy=%b done=%b cnt=%0d full=%b ovf=%b expected mot=%h busy=%b done=%b cnt=%0d full=%b ovf=%b",
               $time, MotCtl, busy, cmd_done, cmd_count, cmd_full, overflow,
               m_mot, m_run, m_done, mq.size(), (mq.size() == DEPTH), m_ovf);
    end
  endtask

  initial begin
    // Directed table: wr, mot, dur, abort, toggle | MotCtl, busy, done, count, overflow
    addv(1, 8'h92, 3, 0, 0,  8'h00, 0, 0, 1, 0);
    addv(0, 8'h00, 0, 0, 0,  8'h92, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h92, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h92, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h00, 0, 1, 0, 0);
    addv(0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    addv(1, 8'h92, 2, 0, 0,  8'h00, 0, 0, 1, 0);
    addv(1, 8'h35, 1, 0, 0,  8'h92, 1, 0, 1, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h92, 1, 0, 1, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h35, 1, 1, 0, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h00, 0, 1, 0, 0);
    addv(0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    addv(1, 8'h11, 0, 0, 0,  8'h00, 0, 0, 1, 0);
    addv(0, 8'h00, 0, 0, 0,  8'h11, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h00, 0, 1, 0, 0);
    addv(1, 8'h55, 4, 1, 0,  8'h00, 0, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    addv(1, 8'h44, 1, 0, 1,  8'h00, 0, 0, 1, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h44, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 0,  8'h44, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 1,  8'h00, 0, 1, 0, 0);

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_mot", MotCtl, 0);
    chk("reset_busy", busy, 0);

    foreach (tq[i]) begin
      step(0, tq[i].wr, tq[i].mot, tq[i].dur, tq[i].ab, tq[i].tog);
      nvec++;
      if (MotCtl !== tq[i].e_mot || busy !== tq[i].e_busy || cmd_done !== tq[i].e_done ||
          cmd_count !== 4'(tq[i].e_cnt) || overflow !== tq[i].e_ovf) begin
        nmis++;
        $display("FAIL vec[%0d]: got mot=%h busy=%b done=%b cnt=%0d ovf=%b expected mot=%h busy=%b done=%b cnt=%0d ovf=%b",
                 i, MotCtl, busy, cmd_done, cmd_count, overflow,
                 tq[i].e_mot, tq[i].e_busy, tq[i].e_done, tq[i].e_cnt, tq[i].e_ovf);
      end
    end

    // Reset mid-command with a pending entry
    step(0, 1, 8'hF3, 5, 0, 0);
    step(0, 1, 8'h12, 2, 0, 0);
    chk("run_mot_f3", MotCtl, 8'hF3);
    chk("run_cnt", cmd_count, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_mid_mot", MotCtl, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cnt", cmd_count, 0);
    chk("rst_mid_ovf", overflow, 0);

    // Fill the queue behind an active command, overflow, then abort
    step(0, 1, 8'h01, 200, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 1, 8'(8'h20 + k), 1, 0, 0);
    chk("fill_full", cmd_full, 1);
    chk("fill_cnt", cmd_count, DEPTH);
    chk("fill_ovf", overflow, 0);
    step(0, 1, 8'hEE, 1, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", cmd_count, DEPTH);
    step(0, 0, 0, 0, 1, 1);
    chk("abort_mot", MotCtl, 0);
    chk("abort_cnt", cmd_count, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_full", cmd_full, 0);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit r, w, a, t;
      logic [7:0] d;
      r = ($urandom_range(0, 299) == 0);
      a = ($urandom_range(0, 49) == 0);
      w = $urandom_range(0, 1) == 1;
      t = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 63) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
      step(r, w, 8'($urandom), d, a, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
